// File: rtl/edge_event_monitor.sv
// Edge-event stage: synchronizes and glitch-filters `a`, then emits registered
// rise/fall pulses, an expected-rise check and saturating event counters.
module edge_event_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             en,
  input  logic             clr,
  input  logic             chk_rise,
  output logic             level,
  output logic             rose,
  output logic             fell,
  output logic             chk_fail,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {ST_LOW, ST_CHK_H, ST_HIGH, ST_CHK_L} state_t;

  localparam int              SW       = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;
  localparam logic [8:0]      FILT_TGT = 9'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic s;

  // Stage p0: input synchronizer, shifts every cycle independent of en
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SW-1:0] sync_p0;
      always_ff @(posedge clk) begin
        if (!rst_n) sync_p0 <= '0;
        else        sync_p0 <= (sync_p0 << 1) | SW'(a);
      end
      assign s = sync_p0[SW-1];
    end else begin : g_nosync
      assign s = a;
    end
  endgenerate

  state_t     state_p1, state_nxt;
  logic [7:0] fc_p1, fc_nxt;
  logic [8:0] fc_inc;
  logic       rose_nxt, fell_nxt, fail_nxt;
  logic       rose_p1, fell_p1, fail_p1;

  // Stage p1: filter FSM state and registered event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_LOW;
      fc_p1    <= '0;
      rose_p1  <= 1'b0;
      fell_p1  <= 1'b0;
      fail_p1  <= 1'b0;
    end else if (en) begin
      state_p1 <= state_nxt;
      fc_p1    <= fc_nxt;
      rose_p1  <= rose_nxt;
      fell_p1  <= fell_nxt;
      fail_p1  <= fail_nxt;
    end else begin
      rose_p1  <= 1'b0;
      fell_p1  <= 1'b0;
      fail_p1  <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    fc_nxt    = fc_p1;
    rose_nxt  = 1'b0;
    fell_nxt  = 1'b0;
    fc_inc    = 9'(fc_p1) + 9'd1;
    case (state_p1)
      ST_LOW: begin
        if (s) begin
          if (FILT_LEN == 1) begin
            state_nxt = ST_HIGH;
            rose_nxt  = 1'b1;
          end else begin
            state_nxt = ST_CHK_H;
            fc_nxt    = 8'd1;
          end
        end
      end
      ST_CHK_H: begin
        if (!s) begin
          state_nxt = ST_LOW;
          fc_nxt    = '0;
        end else if (fc_inc == FILT_TGT) begin
          state_nxt = ST_HIGH;
          fc_nxt    = '0;
          rose_nxt  = 1'b1;
        end else begin
          fc_nxt    = fc_inc[7:0];
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (FILT_LEN == 1) begin
            state_nxt = ST_LOW;
            fell_nxt  = 1'b1;
          end else begin
            state_nxt = ST_CHK_L;
            fc_nxt    = 8'd1;
          end
        end
      end
      ST_CHK_L: begin
        if (s) begin
          state_nxt = ST_HIGH;
          fc_nxt    = '0;
        end else if (fc_inc == FILT_TGT) begin
          state_nxt = ST_LOW;
          fc_nxt    = '0;
          fell_nxt  = 1'b1;
        end else begin
          fc_nxt    = fc_inc[7:0];
        end
      end
      default: begin
        state_nxt = ST_LOW;
        fc_nxt    = '0;
      end
    endcase
    fail_nxt = chk_rise & ~rose_nxt;
  end

  always_comb begin
    level    = (state_p1 == ST_HIGH) || (state_p1 == ST_CHK_L);
    rose     = rose_p1;
    fell     = fell_p1;
    chk_fail = fail_p1;
  end

  // Stage p1: counters update on the same edge their pulse is registered
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      fail_cnt <= '0;
    end else if (en) begin
      if (rose_nxt) rise_cnt <= sat_inc(rise_cnt);
      if (fell_nxt) fall_cnt <= sat_inc(fall_cnt);
      if (fail_nxt) fail_cnt <= sat_inc(fail_cnt);
    end
  end

endmodule

// File: doc/edge_event_monitor.md
Name: edge_event_monitor

Overview:
- Synthesizable edge-event stage that conditions the single-bit stimulus `a` and produces clean, cycle-aligned rise/fall events.
- Semantics match the sampled-value functions `$rose`/`$fell` at `posedge clk`. The pre-reset past value is 0.
- Sits directly downstream of the stimulus driver and feeds scoreboards and assertion logic.
- Adds optional synchronization, glitch filtering, saturating event counters and an in-RTL "expected rise" check that mirrors `assert property(@(posedge clk) $rose(a))`.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on `a` (0..3; 0 = `a` used directly).
- FILT_LEN, 1, consecutive identical samples required to change the filtered level (1..255; 1 = no filtering).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- a  in  1  raw input signal
- en  in  1  monitor enable
- clr  in  1  synchronous counter clear
- chk_rise  in  1  a rise is expected at this sample
- level  out  1  filtered level of `a`
- rose  out  1  one-cycle rise pulse
- fell  out  1  one-cycle fall pulse
- chk_fail  out  1  one-cycle pulse: rise expected but absent
- rise_cnt  out  CNT_W  saturating count of rises
- fall_cnt  out  CNT_W  saturating count of falls
- fail_cnt  out  CNT_W  saturating count of chk_fail events

Behaviour:
- **Reset.** Reset (`rst_n`=0 at posedge, checked before all else) clears:
  - sync flops, FSM (LOW), filter count
  - level, rose, fell, chk_fail
  - all counters
- **Reset mid-operation.** Reset aborts any pending filter qualification. After release, level=0, so a held-high `a` produces a rose.
- **Sample `s`.** `s` is the output of the SYNC_STAGES flop chain, or `a` itself when SYNC_STAGES=0. The sync chain shifts every cycle regardless of `en`.
- **FSM states:** LOW, CHK_H, HIGH, CHK_L, with an 8-bit filter count `fc`.
  - **LOW:**
    - `s`=1 and FILT_LEN=1 -> HIGH with rose.
    - `s`=1 otherwise -> CHK_H, `fc`=1.
  - **CHK_H:**
    - `s`=0 -> LOW, `fc`=0, no event (glitch rejected).
    - `s`=1 and `fc`+1=FILT_LEN -> HIGH with rose.
    - else `fc`++.
  - **HIGH / CHK_L:** symmetric to LOW / CHK_H with `s`=0, producing fell.
- **Outputs.**
  - level=1 in HIGH and CHK_L, 0 otherwise.
  - rose/fell are registered and high for exactly the one cycle following the qualifying edge.
- **Latency.** A change of `a` sampled first at edge k gives a rose/fell pulse after edge k+SYNC_STAGES+FILT_LEN-1.
- **Back-to-back events.** A rise and a fall can occur in consecutive cycles when FILT_LEN=1. Alternating 0/1 each cycle yields alternating rose/fell pulses, never both in one cycle.
- **Expected-rise check.** At each enabled edge, chk_fail is registered as chk_rise AND NOT (rose being registered at that same edge). chk_fail and rose therefore refer to the same sample.
- **Enable.** When `en`=0:
  - FSM, `fc`, level and counters hold.
  - rose, fell and chk_fail are forced 0.
  - Transitions occurring while disabled are seen on re-enable as a level mismatch and qualify normally.
- **Counters.**
  - rise_cnt, fall_cnt and fail_cnt increment on the same edge their pulse is registered.
  - Each saturates at 2^CNT_W-1 with no wrap.
  - `clr`=1 zeroes all three and wins over a simultaneous increment; the pulse itself is still emitted.
  - `clr` does not affect FSM or level.

Test Plan:
- Reset, SYNC_STAGES=0, FILT_LEN=1, `a` sequence 0,1,1,1,1,1,1,0,1,1 applied one per cycle with chk_rise=1 -> rose only after samples 2 and 9, fell after sample 8. chk_fail on the other 8 samples. rise_cnt=2, fall_cnt=1, fail_cnt=8.
- FILT_LEN=3, SYNC_STAGES=0: `a`=1 for 2 cycles then 0 -> no rose, level stays 0. `a`=1 for 3 cycles -> single rose 3 cycles after first high sample, level=1.
- SYNC_STAGES=2, FILT_LEN=1: `a` 0->1 before edge 0 -> rose high after edge 2 only. Reset asserted during CHK_H (FILT_LEN=4) -> all outputs 0, and a held `a`=1 yields rose 4 samples after reset release.
- CNT_W=4: 20 rise/fall pairs -> rise_cnt=fall_cnt=15 saturated. `clr` on the same edge as a rose -> rose pulse seen, rise_cnt=0 next cycle.
- `en`=0 while `a` toggles 0->1->0->1 -> no pulses, counters frozen. `en`=1 with `a`=1 and level=0 -> one rose, rise_cnt +1.
